// File: rtl/nn_vector_harness.sv
// Stimulus/check harness for ready/valid NN blocks: walks a ROM vector range into the DUT,
// applies output back-pressure and scores every DUT output against the expected ROM.
module nn_vector_harness #(
  parameter int IN_W    = 864,
  parameter int OUT_W   = 54,
  parameter int N_VEC   = 100,
  parameter int IDX_W   = 7,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         bp_mode,
  input  logic [IDX_W-1:0]   vec_first,
  input  logic [IDX_W:0]     vec_count,
  output logic [IDX_W-1:0]   stim_addr,
  input  logic [IN_W-1:0]    stim_data,
  output logic [IDX_W-1:0]   exp_addr,
  input  logic [OUT_W-1:0]   exp_data,
  output logic [IN_W-1:0]    dut_in_dat,
  output logic               dut_in_vld,
  input  logic               dut_in_rdy,
  input  logic [OUT_W-1:0]   dut_out_dat,
  input  logic               dut_out_vld,
  output logic               dut_out_rdy,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [IDX_W-1:0]   first_err_idx,
  output logic               timeout_flag
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [1:0]         r_mode;
  logic [IDX_W:0]     r_count;
  logic [IDX_W:0]     r_in_cnt;
  logic [IDX_W:0]     r_out_cnt;
  logic [IDX_W-1:0]   r_stim_addr;
  logic [IDX_W-1:0]   r_exp_addr;
  logic [IDX_W-1:0]   r_first_err;
  logic [15:0]        r_err;
  logic               r_to;
  logic               r_pass;
  logic [TO_W-1:0]    r_to_cnt;
  logic [15:0]        r_lfsr;
  logic               r_tog;
  logic [1:0]         r_phase;

  logic               w_run;
  logic               w_rdy;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_mismatch;
  logic [15:0]        w_err_next;
  logic               w_last;
  logic               w_to_hit;
  logic               w_lfsr_fb;

  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] a);
    return (a == IDX_W'(N_VEC - 1)) ? '0 : a + 1'b1;
  endfunction

  assign w_run = (r_state == S_RUN);

  always_comb begin
    w_rdy = 1'b0;
    case (r_mode)
      2'd0: w_rdy = 1'b1;
      2'd1: w_rdy = r_tog;
      2'd2: w_rdy = r_lfsr[0];
      2'd3: w_rdy = (r_phase == 2'd0);
      default: w_rdy = 1'b0;
    endcase
  end

  assign dut_in_dat  = stim_data;
  assign dut_in_vld  = w_run && (r_in_cnt < r_count);
  assign dut_out_rdy = w_run && w_rdy;

  assign w_in_xfer  = dut_in_vld && dut_in_rdy;
  assign w_out_xfer = dut_out_vld && dut_out_rdy;
  assign w_mismatch = w_out_xfer && (dut_out_dat != exp_data);
  assign w_err_next = (w_mismatch && (r_err != '1)) ? r_err + 16'd1 : r_err;
  assign w_last     = w_out_xfer && ((r_out_cnt + 1'b1) == r_count);
  // Expiry is detected one count early so DONE lands exactly TIMEOUT cycles after RUN entry.
  assign w_to_hit   = !w_out_xfer && (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  assign stim_addr     = r_stim_addr;
  assign exp_addr      = r_exp_addr;
  assign busy          = w_run;
  assign done          = (r_state == S_DONE);
  assign pass          = r_pass;
  assign err_count     = r_err;
  assign first_err_idx = r_first_err;
  assign timeout_flag  = r_to;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= '0;
      r_count     <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_stim_addr <= '0;
      r_exp_addr  <= '0;
      r_first_err <= '0;
      r_err       <= '0;
      r_to        <= 1'b0;
      r_pass      <= 1'b0;
      r_to_cnt    <= '0;
      r_lfsr      <= 16'hACE1;
      r_tog       <= 1'b0;
      r_phase     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mode      <= bp_mode;
            r_count     <= vec_count;
            r_stim_addr <= vec_first;
            r_exp_addr  <= vec_first;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_err       <= '0;
            r_first_err <= '0;
            r_to        <= 1'b0;
            r_to_cnt    <= '0;
            r_tog       <= 1'b1;
            r_phase     <= '0;
            if (vec_count == '0) begin
              r_state <= S_DONE;
              r_pass  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_pass  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (w_in_xfer) begin
            r_in_cnt    <= r_in_cnt + 1'b1;
            r_stim_addr <= f_next(r_stim_addr);
          end
          if (w_out_xfer) begin
            r_out_cnt  <= r_out_cnt + 1'b1;
            r_exp_addr <= f_next(r_exp_addr);
            r_to_cnt   <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
          r_err <= w_err_next;
          if (w_mismatch && (r_err == '0))
            r_first_err <= r_exp_addr;
          r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
          r_tog   <= ~r_tog;
          r_phase <= r_phase + 2'd1;
          if (w_last) begin
            r_state <= S_DONE;
            r_pass  <= (w_err_next == '0) && !r_to;
          end else if (w_to_hit) begin
            r_state <= S_DONE;
            r_to    <= 1'b1;
            r_pass  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_vector_harness.sv
// Directed bench for nn_vector_harness: a table of vector-range runs against a latency
// DUT model with optional corruption, plus hand-written timeout / reset / empty-run sequences.
module tb_nn_vector_harness;

  localparam int IN_W    = 32;
  localparam int OUT_W   = 16;
  localparam int N_VEC   = 100;
  localparam int IDX_W   = 7;
  localparam int TIMEOUT = 64;
  localparam int TO_W    = 7;

  logic               clk;
  logic               rst;
  logic               start;
  logic [1:0]         bp_mode;
  logic [IDX_W-1:0]   vec_first;
  logic [IDX_W:0]     vec_count;
  logic [IDX_W-1:0]   stim_addr;
  logic [IN_W-1:0]    stim_data;
  logic [IDX_W-1:0]   exp_addr;
  logic [OUT_W-1:0]   exp_data;
  logic [IN_W-1:0]    dut_in_dat;
  logic               dut_in_vld;
  logic               dut_in_rdy;
  logic [OUT_W-1:0]   dut_out_dat;
  logic               dut_out_vld;
  logic               dut_out_rdy;
  logic               busy;
  logic               done;
  logic               pass;
  logic [15:0]        err_count;
  logic [IDX_W-1:0]   first_err_idx;
  logic               timeout_flag;

  nn_vector_harness #(
    .IN_W(IN_W), .OUT_W(OUT_W), .N_VEC(N_VEC), .IDX_W(IDX_W),
    .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .bp_mode(bp_mode),
    .vec_first(vec_first), .vec_count(vec_count),
    .stim_addr(stim_addr), .stim_data(stim_data),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .dut_in_dat(dut_in_dat), .dut_in_vld(dut_in_vld), .dut_in_rdy(dut_in_rdy),
    .dut_out_dat(dut_out_dat), .dut_out_vld(dut_out_vld), .dut_out_rdy(dut_out_rdy),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] f_nn(input logic [31:0] x);
    return x[31:16] ^ x[15:0] ^ 16'h5A5A;
  endfunction

  logic [31:0] stim_rom [0:127];
  logic [15:0] exp_rom  [0:127];
  assign stim_data = stim_rom[stim_addr];
  assign exp_data  = exp_rom[exp_addr];

  // DUT model: in-order FIFO with fixed latency; ordinal-selected outputs get bit 0 flipped.
  int          cyc = 0;
  logic [7:0]  wp = '0, rp = '0;
  logic [31:0] qd [0:255];
  int          qt [0:255];
  int          ord = 0;
  int          m_lat = 3;
  bit          m_stall = 1'b0;
  bit          m_clr = 1'b1;
  int          cor_a = -1, cor_b = -1;
  int          rpat = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_clr) begin
      wp  <= '0;
      rp  <= '0;
      ord <= 0;
    end else begin
      if (dut_in_vld && dut_in_rdy) begin
        qd[wp] <= dut_in_dat;
        qt[wp] <= cyc;
        wp     <= wp + 8'd1;
      end
      if (dut_out_vld && dut_out_rdy) begin
        rp  <= rp + 8'd1;
        ord <= ord + 1;
      end
    end
  end

  assign dut_out_vld = !m_stall && (rp != wp) && ((cyc - qt[rp]) >= m_lat);
  assign dut_out_dat = f_nn(qd[rp]) ^ (((ord == cor_a) || (ord == cor_b)) ? 16'h0001 : 16'h0000);
  assign dut_in_rdy  = (rpat == 0) ? 1'b1 : ((cyc % 3) != 0);

  // Monitor: handshake counts, address logs, back-pressure reference, input stability.
  int          in_hs = 0, out_hs = 0, rdy_bad = 0, stab_bad = 0, kcyc = 0;
  logic [1:0]  cur_mode = '0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [IDX_W-1:0] s_log [0:511];
  logic [IDX_W-1:0] e_log [0:511];
  bit          prev_hold = 1'b0;
  logic [IN_W-1:0] prev_dat = '0;

  always @(negedge clk) begin
    logic exp_rdy;
    #1;
    if (rst) begin
      m_lfsr    = 16'hACE1;
      kcyc      = 0;
      prev_hold = 1'b0;
    end else begin
      if (dut_in_vld && dut_in_rdy) begin
        s_log[in_hs % 512] = stim_addr;
        in_hs++;
      end
      if (dut_out_vld && dut_out_rdy) begin
        e_log[out_hs % 512] = exp_addr;
        out_hs++;
      end
      if (busy) begin
        case (cur_mode)
          2'd0: exp_rdy = 1'b1;
          2'd1: exp_rdy = ((kcyc % 2) == 0);
          2'd2: exp_rdy = m_lfsr[0];
          default: exp_rdy = ((kcyc % 4) == 0);
        endcase
        if (dut_out_rdy !== exp_rdy) rdy_bad++;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        kcyc++;
      end else begin
        kcyc = 0;
        if (dut_out_rdy !== 1'b0) rdy_bad++;
      end
      if (prev_hold && dut_in_vld && (dut_in_dat !== prev_dat)) stab_bad++;
      prev_hold = dut_in_vld && !dut_in_rdy;
      prev_dat  = dut_in_dat;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run(input logic [1:0] m, input int first, input int cnt, output int cyc_n);
    @(negedge clk);
    bp_mode   = m;
    cur_mode  = m;
    vec_first = IDX_W'(first);
    vec_count = (IDX_W+1)'(cnt);
    start     = 1'b1;
    m_clr     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_clr = 1'b0;
    cyc_n = 0;
    while (!done && cyc_n < 3000) begin
      @(negedge clk);
      cyc_n++;
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    int first, cnt, ca, cb, rp;
    bit exp_pass;
    int exp_err, exp_fe;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int cyc_n, b_in, b_out, b_rdy, b_stab, bad, w;
    tbl[0] = '{2'd0,  3,   1, -1, -1, 0, 1'b1, 0,  0};
    tbl[1] = '{2'd2,  0, 100, -1, -1, 0, 1'b1, 0,  0};
    tbl[2] = '{2'd1,  0,  20,  5, 17, 1, 1'b0, 2,  5};
    tbl[3] = '{2'd3, 98,   4, -1, -1, 0, 1'b1, 0,  0};
    tbl[4] = '{2'd0, 50,  10,  0, -1, 1, 1'b0, 1, 50};
    tbl[5] = '{2'd2, 95,   8,  7, -1, 0, 1'b0, 1,  2};

    for (int i = 0; i < 128; i++) begin
      stim_rom[i] = {8'(i), 8'(i * 7 + 1), 8'(i * 13 + 5), 8'(255 - i)};
      exp_rom[i]  = f_nn(stim_rom[i]);
    end

    rst = 1'b1; start = 1'b0; bp_mode = '0; vec_first = '0; vec_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_outs", {err_count, first_err_idx, timeout_flag, stim_addr, exp_addr, dut_in_vld, dut_out_rdy}, 0);
    rst = 1'b0;

    foreach (tbl[t]) begin
      cor_a = tbl[t].ca; cor_b = tbl[t].cb; rpat = tbl[t].rp; m_stall = 1'b0;
      b_in = in_hs; b_out = out_hs; b_rdy = rdy_bad; b_stab = stab_bad;
      run(tbl[t].mode, tbl[t].first, tbl[t].cnt, cyc_n);
      chk($sformatf("v%0d_done", t), done, 1);
      chk($sformatf("v%0d_busy", t), busy, 0);
      chk($sformatf("v%0d_pass", t), pass, tbl[t].exp_pass);
      chk($sformatf("v%0d_err", t), err_count, tbl[t].exp_err);
      chk($sformatf("v%0d_first_err", t), first_err_idx, tbl[t].exp_fe);
      chk($sformatf("v%0d_timeout", t), timeout_flag, 0);
      chk($sformatf("v%0d_in_hs", t), in_hs - b_in, tbl[t].cnt);
      chk($sformatf("v%0d_out_hs", t), out_hs - b_out, tbl[t].cnt);
      bad = 0;
      for (int j = 0; j < tbl[t].cnt; j++) begin
        if (int'(s_log[(b_in + j) % 512])  != (tbl[t].first + j) % N_VEC) bad++;
        if (int'(e_log[(b_out + j) % 512]) != (tbl[t].first + j) % N_VEC) bad++;
      end
      chk($sformatf("v%0d_addr_seq", t), bad, 0);
      chk($sformatf("v%0d_rdy_pattern", t), rdy_bad - b_rdy, 0);
      chk($sformatf("v%0d_in_stable", t), stab_bad - b_stab, 0);
    end

    // Timeout: outputs never become valid.
    m_stall = 1'b1; rpat = 0; cor_a = -1; cor_b = -1;
    b_in = in_hs; b_out = out_hs;
    run(2'd0, 0, 10, cyc_n);
    chk("to_done", done, 1);
    chk("to_latency", cyc_n, 64);
    chk("to_flag", timeout_flag, 1);
    chk("to_pass", pass, 0);
    chk("to_in_hs", in_hs - b_in, 10);
    chk("to_out_hs", out_hs - b_out, 0);

    // Reset pulse after ten input transfers.
    b_in = in_hs;
    @(negedge clk);
    bp_mode = 2'd0; cur_mode = 2'd0; vec_first = '0; vec_count = 8'd50;
    start = 1'b1; m_clr = 1'b1;
    @(negedge clk);
    start = 1'b0; m_clr = 1'b0;
    w = 0;
    while ((in_hs - b_in) < 10 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("mid_in_cnt", in_hs - b_in, 10);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_flags", {busy, done, pass, timeout_flag}, 0);
    chk("mid_rst_outs", {err_count, first_err_idx, stim_addr, exp_addr, dut_in_vld, dut_out_rdy}, 0);
    rst = 1'b0;
    m_stall = 1'b0;

    // Empty run: straight to DONE with pass.
    b_in = in_hs; b_out = out_hs;
    run(2'd0, 5, 0, cyc_n);
    chk("empty_latency", cyc_n, 0);
    chk("empty_done_pass", {done, pass, busy}, 3'b110);
    chk("empty_hs", (in_hs - b_in) + (out_hs - b_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
